menu_button_ctrl: RTL and testbench

//  Front end for the ATM menu stage: synchronises and debounces the four raw board buttons.

---
 rtl/menu_button_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_menu_button_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/menu_button_ctrl.sv
// Menu button front end: synchronises and debounces the four board buttons,
// auto-repeats up/down while held, and owns the registered menu index.

// One button: 2-flop synchroniser, stable-count debounce and rising-edge event.
module menu_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_d;

  // Synchronise the pin, then accept a new level only after it has been stable long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync    <= {sync[0], raw};
      level_d <= level;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Press event is high in the cycle the debounced level has just risen; releases are ignored.
  assign press = level & ~level_d;
endmodule

// Auto-repeat for one held button.
//   state  | meaning
//   IDLE   | button released, waiting for a press event
//   HOLD   | pressed, counting down the initial hold delay
//   REPEAT | still held, emitting an event every REPEAT_CYCLES
module menu_autorepeat #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  input  logic press,
  output logic evt
);
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? TW'(HOLD_CYCLES - 1) : '0;
  localparam logic [TW-1:0] REP_LOAD  = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_t;

  rpt_state_t    state, state_next;
  logic [TW-1:0] timer, timer_next;

  // State and timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // Down-count to zero; a falling level always wins so no event fires after release.
  always_comb begin
    state_next = state;
    timer_next = timer;
    evt        = 1'b0;
    case (state)
      IDLE: begin
        if (press) begin
          evt        = 1'b1;
          state_next = HOLD;
          timer_next = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (!level) begin
          state_next = IDLE;
        end else if (HOLD_CYCLES != 0) begin
          if (timer == '0) begin
            evt        = 1'b1;
            state_next = REPEAT;
            timer_next = REP_LOAD;
          end else begin
            timer_next = timer - 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!level) begin
          state_next = IDLE;
        end else if (timer == '0) begin
          evt        = 1'b1;
          timer_next = REP_LOAD;
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

module menu_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 25_000_000,
  parameter int NUM_ITEMS       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BTNU,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       BTNR,
  output logic [1:0] menu_sel,
  output logic       sel_changed,
  output logic       back_pulse,
  output logic       select_pulse,
  output logic [3:0] btn_level
);
  localparam logic [1:0] LAST_ITEM = 2'(NUM_ITEMS - 1);

  logic [3:0] raw;
  logic [3:0] press;
  logic       up_evt;
  logic       down_evt;

  // Bit order {U,D,L,R} throughout.
  assign raw = {BTNU, BTND, BTNL, BTNR};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    menu_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[i]),
      .level (btn_level[i]),
      .press (press[i])
    );
  end

  menu_autorepeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_rpt_up (
    .clk   (clk),
    .rst_n (rst_n),
    .level (btn_level[3]),
    .press (press[3]),
    .evt   (up_evt)
  );

  menu_autorepeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_rpt_down (
    .clk   (clk),
    .rst_n (rst_n),
    .level (btn_level[2]),
    .press (press[2]),
    .evt   (down_evt)
  );

  // Menu index with wrap-around; simultaneous up and down cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      menu_sel     <= '0;
      sel_changed  <= 1'b0;
      back_pulse   <= 1'b0;
      select_pulse <= 1'b0;
    end else begin
      sel_changed  <= 1'b0;
      back_pulse   <= press[1];
      select_pulse <= press[0];
      if (up_evt && !down_evt) begin
        menu_sel    <= (menu_sel == 2'd0) ? LAST_ITEM : menu_sel - 2'd1;
        sel_changed <= 1'b1;
      end else if (down_evt && !up_evt) begin
        menu_sel    <= (menu_sel == LAST_ITEM) ? 2'd0 : menu_sel + 2'd1;
        sel_changed <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_menu_button_ctrl.sv
// Directed bench for menu_button_ctrl with short debounce/hold/repeat times.
module tb_menu_button_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] btn = 4'b0000;   // {U,D,L,R}
  logic [1:0] menu_sel;
  logic       sel_changed;
  logic       back_pulse;
  logic       select_pulse;
  logic [3:0] btn_level;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int sc_q[$];
  int sel_q[$];
  int back_q[$];

  menu_button_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(20),
    .REPEAT_CYCLES(8),
    .NUM_ITEMS(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .BTNU         (btn[3]),
    .BTND         (btn[2]),
    .BTNL         (btn[1]),
    .BTNR         (btn[0]),
    .menu_sel     (menu_sel),
    .sel_changed  (sel_changed),
    .back_pulse   (back_pulse),
    .select_pulse (select_pulse),
    .btn_level    (btn_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record the cycle number of every strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (sel_changed === 1'b1)  sc_q.push_back(cyc);
    if (select_pulse === 1'b1) sel_q.push_back(cyc);
    if (back_pulse === 1'b1)   back_q.push_back(cyc);
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    sc_q.delete();
    sel_q.delete();
    back_q.delete();
  endtask

  // Hold one button for the given number of cycles, release, then let it settle.
  task automatic press_btn(input int idx, input int hold);
    btn[idx] = 1'b1;
    cycles(hold);
    btn[idx] = 1'b0;
    cycles(12);
  endtask

  task automatic test_reset();
    cycles(2);
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (menu_sel !== 2'd0) $display("FAIL reset_menu_sel: got %0d expected 0", menu_sel); else passed++;
    total++; if (sel_changed !== 1'b0) $display("FAIL reset_sel_changed: got %b expected 0", sel_changed); else passed++;
    total++; if (back_pulse !== 1'b0) $display("FAIL reset_back_pulse: got %b expected 0", back_pulse); else passed++;
    total++; if (select_pulse !== 1'b0) $display("FAIL reset_select_pulse: got %b expected 0", select_pulse); else passed++;
    total++; if (btn_level !== 4'b0000) $display("FAIL reset_btn_level: got %b expected 0000", btn_level); else passed++;
    cycles(3);
    rst_n = 1'b1;
    clear_logs();
    cycles(10);
    total++; if (menu_sel !== 2'd0) $display("FAIL idle_menu_sel: got %0d expected 0", menu_sel); else passed++;
    total++; if (sc_q.size() + sel_q.size() + back_q.size() != 0)
      $display("FAIL idle_strobes: got %0d expected 0", sc_q.size() + sel_q.size() + back_q.size()); else passed++;
  endtask

  task automatic test_down_steps();
    int pin_cyc;
    clear_logs();
    btn[2] = 1'b1;
    pin_cyc = cyc;
    cycles(6);
    total++; if (menu_sel !== 2'd0) $display("FAIL down_early: got %0d expected 0", menu_sel); else passed++;
    cycles(1);
    total++; if (menu_sel !== 2'd1) $display("FAIL down_first: got %0d expected 1", menu_sel); else passed++;
    total++; if (sel_changed !== 1'b1) $display("FAIL down_strobe: got %b expected 1", sel_changed); else passed++;
    total++; if (btn_level !== 4'b0100) $display("FAIL down_level: got %b expected 0100", btn_level); else passed++;
    cycles(3);
    btn[2] = 1'b0;
    cycles(12);
    total++; if (sc_q.size() != 1 || sc_q[0] != pin_cyc + 7)
      $display("FAIL down_latency: got %0d strobes, first at +%0d, expected 1 at +7",
               sc_q.size(), (sc_q.size() > 0) ? sc_q[0] - pin_cyc : -1); else passed++;
    press_btn(2, 10);
    total++; if (menu_sel !== 2'd2) $display("FAIL down_to_2: got %0d expected 2", menu_sel); else passed++;
    press_btn(2, 10);
    total++; if (menu_sel !== 2'd3) $display("FAIL down_to_3: got %0d expected 3", menu_sel); else passed++;
    press_btn(2, 10);
    total++; if (menu_sel !== 2'd0) $display("FAIL down_wrap: got %0d expected 0", menu_sel); else passed++;
    press_btn(3, 10);
    total++; if (menu_sel !== 2'd3) $display("FAIL up_wrap: got %0d expected 3", menu_sel); else passed++;
    total++; if (sc_q.size() != 5) $display("FAIL down_count: got %0d expected 5", sc_q.size()); else passed++;
  endtask

  task automatic test_glitch();
    clear_logs();
    repeat (6) begin
      btn[3] = 1'b1;
      cycles(3);
      btn[3] = 1'b0;
      cycles(3);
    end
    cycles(10);
    total++; if (sc_q.size() != 0) $display("FAIL glitch_strobes: got %0d expected 0", sc_q.size()); else passed++;
    total++; if (menu_sel !== 2'd3) $display("FAIL glitch_menu_sel: got %0d expected 3", menu_sel); else passed++;
    press_btn(3, 10);
    total++; if (sc_q.size() != 1) $display("FAIL glitch_stable_count: got %0d expected 1", sc_q.size()); else passed++;
    total++; if (menu_sel !== 2'd2) $display("FAIL glitch_stable_sel: got %0d expected 2", menu_sel); else passed++;
  endtask

  task automatic test_autorepeat();
    int pin_cyc;
    int exp_gap[5] = '{20, 8, 8, 8, 8};
    press_btn(2, 10);
    press_btn(2, 10);
    total++; if (menu_sel !== 2'd0) $display("FAIL rpt_start: got %0d expected 0", menu_sel); else passed++;
    clear_logs();
    btn[2] = 1'b1;
    pin_cyc = cyc;
    cycles(60);
    btn[2] = 1'b0;
    cycles(20);
    total++; if (sc_q.size() != 6) $display("FAIL rpt_count: got %0d expected 6", sc_q.size()); else passed++;
    if (sc_q.size() == 6) begin
      total++; if (sc_q[0] != pin_cyc + 7)
        $display("FAIL rpt_first: got +%0d expected +7", sc_q[0] - pin_cyc); else passed++;
      for (int i = 0; i < 5; i++) begin
        total++; if (sc_q[i+1] - sc_q[i] != exp_gap[i])
          $display("FAIL rpt_gap%0d: got %0d expected %0d", i, sc_q[i+1] - sc_q[i], exp_gap[i]); else passed++;
      end
    end
    total++; if (menu_sel !== 2'd2) $display("FAIL rpt_menu_sel: got %0d expected 2", menu_sel); else passed++;
    cycles(30);
    total++; if (sc_q.size() != 6 || menu_sel !== 2'd2)
      $display("FAIL rpt_after_release: got %0d strobes sel %0d expected 6 sel 2", sc_q.size(), menu_sel); else passed++;
  endtask

  task automatic test_simultaneous();
    clear_logs();
    btn[3] = 1'b1;
    btn[2] = 1'b1;
    cycles(10);
    btn[3] = 1'b0;
    btn[2] = 1'b0;
    cycles(12);
    total++; if (sc_q.size() != 0) $display("FAIL ud_strobes: got %0d expected 0", sc_q.size()); else passed++;
    total++; if (menu_sel !== 2'd2) $display("FAIL ud_menu_sel: got %0d expected 2", menu_sel); else passed++;
    btn[1] = 1'b1;
    btn[0] = 1'b1;
    cycles(10);
    btn[1] = 1'b0;
    btn[0] = 1'b0;
    cycles(12);
    total++; if (sel_q.size() != 1) $display("FAIL lr_select_count: got %0d expected 1", sel_q.size()); else passed++;
    total++; if (back_q.size() != 1) $display("FAIL lr_back_count: got %0d expected 1", back_q.size()); else passed++;
    if (sel_q.size() == 1 && back_q.size() == 1) begin
      total++; if (sel_q[0] != back_q[0])
        $display("FAIL lr_same_cycle: got select %0d back %0d expected equal", sel_q[0], back_q[0]); else passed++;
    end
    total++; if (menu_sel !== 2'd2) $display("FAIL lr_menu_sel: got %0d expected 2", menu_sel); else passed++;
  endtask

  task automatic test_reset_mid_press();
    int rel_cyc;
    btn[0] = 1'b1;
    cycles(12);
    clear_logs();
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    rel_cyc = cyc;
    cycles(15);
    total++; if (sel_q.size() != 1) $display("FAIL rst_hold_count: got %0d expected 1", sel_q.size()); else passed++;
    if (sel_q.size() == 1) begin
      total++; if (sel_q[0] != rel_cyc + 7)
        $display("FAIL rst_hold_latency: got +%0d expected +7", sel_q[0] - rel_cyc); else passed++;
    end
    total++; if (btn_level !== 4'b0001) $display("FAIL rst_hold_level: got %b expected 0001", btn_level); else passed++;
    total++; if (menu_sel !== 2'd0 || back_q.size() != 0)
      $display("FAIL rst_hold_other: got sel %0d back %0d expected 0 0", menu_sel, back_q.size()); else passed++;
    btn[0] = 1'b0;
    cycles(12);
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_down_steps();
        test_glitch();
        test_autorepeat();
        test_simultaneous();
        test_reset_mid_press();
      end
      begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1);
      end
    join_any
    disable fork;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
